mux_2_1_rr_arbiter: RTL



---
 rtl/mux_2_1_rr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mux_2_1_rr_arbiter.sv
// mux_2_1_rr_arbiter
// Round-robin arbiter and sequencer for a shared 2:1 mux datapath.
// Two requesters compete for the mux. The winner's words pass through
// a registered valid/ready output stage. The arbiter drives the mux
// select line.
//
// Optional feature: define MUX_ARB_BURST_LIMIT_EN to cap each grant at
// MAX_BURST accepted words while the other requester is waiting.
// Without the macro, a grant lasts as long as its request stays high.

module mux_2_1_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] data0,
    input  logic [DW-1:0] data1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          acc0,
    output logic          acc1,
    output logic          sel,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    // The burst counter is 8 bits wide, so the limit must fit in 1..255.
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
        $error("mux_2_1_rr_arbiter: MAX_BURST must be in 1..255");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last;
    logic       last_nxt;
    logic       out_free;
    logic       burst_sw0;
    logic       burst_sw1;

    assign gnt0     = (state == OWN0);
    assign gnt1     = (state == OWN1);
    assign out_free = !out_valid || out_ready;
    assign acc0     = gnt0 && req0 && out_free;
    assign acc1     = gnt1 && req1 && out_free;

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    logic [7:0] burst_cnt;

    // Force a handoff when the final word of a burst is accepted while
    // the other requester is waiting.
    assign burst_sw0 = acc0 && (burst_cnt == BURST_LAST) && req1;
    assign burst_sw1 = acc1 && (burst_cnt == BURST_LAST) && req0;

    // Count accepts in the current grant. Clear on any grant change and
    // saturate at the last burst slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= 8'd0;
        end else if (state_nxt != state) begin
            burst_cnt <= 8'd0;
        end else if ((acc0 || acc1) && (burst_cnt != BURST_LAST)) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end
`else
    assign burst_sw0 = 1'b0;
    assign burst_sw1 = 1'b0;
`endif

    // Next-state and priority logic. Handoff between requesters is
    // direct, with no IDLE bubble.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!req0 || burst_sw0) begin
                    last_nxt  = 1'b0;
                    state_nxt = req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!req1 || burst_sw1) begin
                    last_nxt  = 1'b1;
                    state_nxt = req0 ? OWN0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register the FSM state and the priority pointer. The select line
    // follows the owner and holds its value in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (state_nxt == OWN0) begin
                sel <= 1'b0;
            end else if (state_nxt == OWN1) begin
                sel <= 1'b1;
            end
        end
    end

    // Output slot: load it on an accept, or empty it when the consumer
    // takes the word and nothing new arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (acc0) begin
            out_valid <= 1'b1;
            out_data  <= data0;
        end else if (acc1) begin
            out_valid <= 1'b1;
            out_data  <= data1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
